// File: rtl/collenda_gpio_pkg.sv
//------------------------------------------------------------------------------
// Module   : collenda_gpio_pkg
// Purpose  : Register map and parameter encodings shared by the GPIO block.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package collenda_gpio_pkg;

   typedef enum logic [2:0] {
      ADDR_DATA      = 3'd0,
      ADDR_DIRECTION = 3'd1,
      ADDR_IRQMASK   = 3'd2,
      ADDR_EDGECAP   = 3'd3,
      ADDR_OUTSET    = 3'd4,
      ADDR_OUTCLEAR  = 3'd5,
      ADDR_RSVD6     = 3'd6,
      ADDR_RSVD7     = 3'd7
   } gpio_addr_e;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   localparam int IRQ_LEVEL = 0;
   localparam int IRQ_EDGE  = 1;

   localparam int BUS_WIDTH = 32;

endpackage : collenda_gpio_pkg

`default_nettype wire

// File: rtl/collenda_gpio_sync.sv
//------------------------------------------------------------------------------
// Module   : collenda_gpio_sync
// Purpose  : Input synchroniser, history flop, warm-up gate and edge detector.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module collenda_gpio_sync
   import collenda_gpio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] sync_in,
   output logic [WIDTH-1:0] edge_det
);

   localparam int                WARM_CYCLES = SYNC_STAGES + 1;
   localparam int                CNT_W       = $clog2(WARM_CYCLES + 1);
   localparam logic [CNT_W-1:0]  C_WARM_DONE = CNT_W'(WARM_CYCLES);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
   logic [WIDTH-1:0]                  r_hist;
   logic [CNT_W-1:0]                  r_warm_cnt;
   logic                              w_warm_done;
   logic [WIDTH-1:0]                  w_edge_raw;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= '0;
         r_hist <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   // Holds off capture until the chain and history flop contain real pin data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_warm_cnt <= '0;
      end else if (!w_warm_done) begin
         r_warm_cnt <= r_warm_cnt + 1'b1;
      end
   end

   assign w_warm_done = (r_warm_cnt == C_WARM_DONE);
   assign sync_in     = r_sync[SYNC_STAGES-1];

   generate
      if (EDGE_TYPE == EDGE_FALL) begin : g_edge_fall
         assign w_edge_raw = ~sync_in & r_hist;
      end else if (EDGE_TYPE == EDGE_ANY) begin : g_edge_any
         assign w_edge_raw = sync_in ^ r_hist;
      end else begin : g_edge_rise
         assign w_edge_raw = sync_in & ~r_hist;
      end
   endgenerate

   assign edge_det = w_warm_done ? w_edge_raw : '0;

endmodule : collenda_gpio_sync

`default_nettype wire

// File: rtl/collenda_gpio.sv
//------------------------------------------------------------------------------
// Module   : collenda_gpio
// Purpose  : Memory-mapped GPIO port with direction, edge capture and IRQ.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module collenda_gpio
   import collenda_gpio_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               EDGE_TYPE   = EDGE_RISE,
   parameter int               IRQ_MODE    = IRQ_EDGE,
   parameter int               SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [2:0]           address,
   input  logic                 chipselect,
   input  logic                 write_n,
   input  logic [BUS_WIDTH-1:0] writedata,
   output logic [BUS_WIDTH-1:0] readdata,
   input  logic [WIDTH-1:0]     in_port,
   output logic [WIDTH-1:0]     out_port,
   output logic [WIDTH-1:0]     out_oe,
   output logic                 irq
);

   logic [WIDTH-1:0]     r_data_out;
   logic [WIDTH-1:0]     r_direction;
   logic [WIDTH-1:0]     r_irqmask;
   logic [WIDTH-1:0]     r_edgecap;
   logic [BUS_WIDTH-1:0] r_readdata;

   logic [WIDTH-1:0]     w_sync_in;
   logic [WIDTH-1:0]     w_edge_det;
   logic [WIDTH-1:0]     w_wdata;
   logic [WIDTH-1:0]     w_w1c;
   logic                 w_wr;
   logic [BUS_WIDTH-1:0] w_rd_next;

   collenda_gpio_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_port  (in_port),
      .sync_in  (w_sync_in),
      .edge_det (w_edge_det)
   );

   assign w_wr    = chipselect & ~write_n;
   assign w_wdata = writedata[WIDTH-1:0];
   assign w_w1c   = (w_wr && (address == ADDR_EDGECAP)) ? w_wdata : '0;

   generate
      if (WIDTH < BUS_WIDTH) begin : g_wdata_hi
         logic w_unused_wdata_hi;
         assign w_unused_wdata_hi = |writedata[BUS_WIDTH-1:WIDTH];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data_out  <= RESET_VALUE;
         r_direction <= '0;
         r_irqmask   <= '0;
      end else if (w_wr) begin
         case (address)
            ADDR_DATA:      r_data_out  <= w_wdata;
            ADDR_DIRECTION: r_direction <= w_wdata;
            ADDR_IRQMASK:   r_irqmask   <= w_wdata;
            ADDR_OUTSET:    r_data_out  <= r_data_out | w_wdata;
            ADDR_OUTCLEAR:  r_data_out  <= r_data_out & ~w_wdata;
            default:        ;
         endcase
      end
   end

   // Capture is OR-ed in after the clear so a simultaneous edge is never lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_edgecap <= '0;
      end else begin
         r_edgecap <= (r_edgecap & ~w_w1c) | w_edge_det;
      end
   end

   always_comb begin
      w_rd_next = '0;
      case (address)
         ADDR_DATA:      w_rd_next = BUS_WIDTH'(w_sync_in);
         ADDR_DIRECTION: w_rd_next = BUS_WIDTH'(r_direction);
         ADDR_IRQMASK:   w_rd_next = BUS_WIDTH'(r_irqmask);
         ADDR_EDGECAP:   w_rd_next = BUS_WIDTH'(r_edgecap);
         default:        w_rd_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_readdata <= '0;
      end else begin
         r_readdata <= w_rd_next;
      end
   end

   generate
      if (IRQ_MODE == IRQ_LEVEL) begin : g_irq_level
         assign irq = |(w_sync_in & r_irqmask);
      end else begin : g_irq_edge
         assign irq = |(r_edgecap & r_irqmask);
      end
   endgenerate

   assign readdata = r_readdata;
   assign out_port = r_data_out;
   assign out_oe   = r_direction;

endmodule : collenda_gpio

`default_nettype wire
